nn_stream_decode: RTL and testbench
===================================

NN_STREAM_DECODE -- requirements
Module: nn_stream_decode

Interface
REQ-001 Parameter N_BITS, default 8; window length = 2^N_BITS enabled cycles.
REQ-002 Parameter CONTINUOUS, default 1; 1 = back-to-back windows, 0 = single window per START.
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 INIT  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 IN  input  1  stochastic bitstream sample (node activation a_out or z).
REQ-006 SIGN_IN  input  1  sample polarity; 0 = positive, 1 = negative.
REQ-007 EN  input  1  sample qualifier; cycles with EN=0 are ignored entirely.
REQ-008 START  input  1  begin (or restart) a window.
REQ-009 RDY  input  1  downstream consumer ready.
REQ-010 VALUE  output  N_BITS+2  signed two's-complement window sum.
REQ-011 VALID  output  1  VALUE holds an unconsumed result.
REQ-012 OVERRUN  output  1  one-cycle pulse: unconsumed result overwritten.
REQ-013 BUSY  output  1  high while in ACCUM state.

Function
REQ-014 States: IDLE, ACCUM; INIT forces IDLE.
REQ-015 IDLE + START -> ACCUM next cycle; sample counter and accumulator cleared; START-cycle sample not counted.
REQ-016 ACCUM + START -> window aborted, counter/accumulator cleared, remain ACCUM; partial sum discarded; START-cycle sample not counted.
REQ-017 ACCUM, EN=1, START=0: accumulator += +1 if IN&~SIGN_IN, -1 if IN&SIGN_IN, 0 if ~IN; sample counter += 1.
REQ-018 Accumulator width N_BITS+2, signed; range -2^N_BITS..+2^N_BITS, no saturation needed, no wrap permitted.
REQ-019 Sample counter width N_BITS; capture occurs on the EN=1 cycle where counter = 2^N_BITS-1, including that cycle's sample.
REQ-020 Capture: VALUE loaded with final sum, VALID=1 from the next cycle (latency 1 cycle after last sample).
REQ-021 On capture, CONTINUOUS=1: stay ACCUM with counter and accumulator cleared, next EN cycle is sample 0 of new window; CONTINUOUS=0: go IDLE.
REQ-022 Handshake: VALID&RDY on a cycle -> VALID=0 next cycle, unless a capture occurs that same cycle.
REQ-023 Capture with VALID=1 and RDY=1 same cycle: VALUE updated, VALID stays 1, OVERRUN stays 0.
REQ-024 Capture with VALID=1 and RDY=0: VALUE overwritten with new sum, VALID stays 1, OVERRUN=1 for exactly one cycle.
REQ-025 VALUE stable whenever VALID=1 and no capture occurs.
REQ-026 VALUE, VALID unaffected by START; a pending result survives a restart.
REQ-027 BUSY=1 exactly when state = ACCUM.
REQ-028 EN=0 in ACCUM: counter, accumulator, state hold.

Reset
REQ-029 INIT=1: state IDLE, counter 0, accumulator 0, VALUE 0, VALID 0, OVERRUN 0, BUSY 0, asynchronously, independent of CLK.
REQ-030 INIT asserted mid-window: partial sum lost; after release block waits in IDLE for START.
REQ-031 INIT deassertion takes effect at the next rising CLK; no capture on the first post-reset edge.

Verification (N_BITS=3, window 8)
REQ-032 CONTINUOUS=0, START, 8 EN cycles IN=1 SIGN_IN=0, RDY=1 -> VALID one cycle later, VALUE=+8, then VALID=0, BUSY=0.
REQ-033 Pattern IN=1 x5 SIGN_IN=1, IN=1 x2 SIGN_IN=0, IN=0 x1 -> VALUE=-3 (5'b11101).
REQ-034 CONTINUOUS=1, RDY=0, 16 EN cycles IN=1 SIGN_IN=0 -> first VALUE=+8, second capture OVERRUN pulse one cycle, VALUE=+8, VALID held.
REQ-035 EN toggled 1/0 over 16 cycles with IN=1 -> capture only after 8th enabled cycle, VALUE=+8.
REQ-036 START at enabled sample 5 of a window -> no capture at original boundary; capture 8 enabled cycles after restart with sum of new samples only.
REQ-037 INIT pulse at sample 4 with VALID=1 -> VALUE=0, VALID=0, BUSY=0 immediately; no further capture until START.

Source files
------------

// File: rtl/nn_stream_decode.sv
// nn_stream_decode: sums a signed stochastic bitstream over windows of 2^N_BITS enabled samples.
//
// Ports:
//   clk_i      rising-edge clock
//   init_i     asynchronous active-high reset
//   in_i       bitstream sample
//   sign_in_i  sample polarity (0 = +1, 1 = -1)
//   en_i       sample qualifier; cycles with en_i=0 are ignored
//   start_i    begin or restart a window (its own sample is not counted)
//   rdy_i      downstream consumer ready
//   value_o    signed window sum
//   valid_o    value_o holds an unconsumed result
//   overrun_o  one-cycle pulse when an unconsumed result is overwritten
//   busy_o     high while accumulating
module nn_stream_decode #(
    parameter int unsigned N_BITS     = 8,
    parameter bit          CONTINUOUS = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     init_i,
    input  logic                     in_i,
    input  logic                     sign_in_i,
    input  logic                     en_i,
    input  logic                     start_i,
    input  logic                     rdy_i,
    output logic signed [N_BITS+1:0] value_o,
    output logic                     valid_o,
    output logic                     overrun_o,
    output logic                     busy_o
);

    localparam int unsigned AccW = N_BITS + 2;
    localparam logic [N_BITS-1:0] CntLast = {N_BITS{1'b1}};

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e                 state_q, state_d;
    logic [N_BITS-1:0]      cnt_q, cnt_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [AccW-1:0] value_q, value_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;

    logic signed [AccW-1:0] delta;
    logic signed [AccW-1:0] acc_sum;
    logic                   capture;

    // Sample contribution: +1, -1 (all ones) or 0.
    always_comb begin
        delta = '0;
        if (in_i) begin
            delta = sign_in_i ? '1 : AccW'(1);
        end
    end

    assign acc_sum = acc_q + delta;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            StAccum: begin
                if (start_i) begin
                    // Restart discards the partial window.
                    cnt_d = '0;
                    acc_d = '0;
                end else if (en_i) begin
                    if (cnt_q == CntLast) begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                        if (!CONTINUOUS) begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + N_BITS'(1);
                        acc_d = acc_sum;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result register and handshake; a capture wins over a same-cycle consume.
    always_comb begin
        value_d   = value_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && rdy_i) begin
            valid_d = 1'b0;
        end
        if (capture) begin
            value_d   = acc_sum;
            valid_d   = 1'b1;
            overrun_d = valid_q && !rdy_i;
        end
    end

    always_ff @(posedge clk_i or posedge init_i) begin
        if (init_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign value_o   = value_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
    assign busy_o    = (state_q == StAccum);

endmodule

// File: tb/tb_nn_stream_decode.sv
// tb_nn_stream_decode: self-checking bench for nn_stream_decode with N_BITS=3 (window of 8).
// Two instances share the stimulus: dut_c (CONTINUOUS=1) and dut_s (CONTINUOUS=0).
module tb_nn_stream_decode;

    logic clk;
    logic init;
    logic din;
    logic sign;
    logic en;
    logic start;
    logic rdy;

    logic signed [4:0] value_c, value_s;
    logic              valid_c, valid_s;
    logic              overrun_c, overrun_s;
    logic              busy_c, busy_s;

    int tests_run;
    int tests_failed;

    // Reference model, index 0 = single-window, 1 = continuous.
    int                m_samp[2][8];
    int                m_n[2];
    bit                m_act[2];
    logic signed [4:0] m_value[2];
    bit                m_valid[2];
    bit                m_overrun[2];

    nn_stream_decode #(.N_BITS(3), .CONTINUOUS(1'b1)) dut_c (
        .clk_i     (clk),
        .init_i    (init),
        .in_i      (din),
        .sign_in_i (sign),
        .en_i      (en),
        .start_i   (start),
        .rdy_i     (rdy),
        .value_o   (value_c),
        .valid_o   (valid_c),
        .overrun_o (overrun_c),
        .busy_o    (busy_c)
    );

    nn_stream_decode #(.N_BITS(3), .CONTINUOUS(1'b0)) dut_s (
        .clk_i     (clk),
        .init_i    (init),
        .in_i      (din),
        .sign_in_i (sign),
        .en_i      (en),
        .start_i   (start),
        .rdy_i     (rdy),
        .value_o   (value_s),
        .valid_o   (valid_s),
        .overrun_o (overrun_s),
        .busy_o    (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k]       = 0;
            m_act[k]     = 1'b0;
            m_value[k]   = '0;
            m_valid[k]   = 1'b0;
            m_overrun[k] = 1'b0;
        end
    endtask

    // Applies one rising edge to the model using the current inputs.
    task automatic model_edge();
        int  sum;
        bit  cap;
        bit  prev;
        for (int k = 0; k < 2; k++) begin
            cap = 1'b0;
            sum = 0;
            if (!m_act[k]) begin
                if (start) begin
                    m_act[k] = 1'b1;
                    m_n[k]   = 0;
                end
            end else if (start) begin
                m_n[k] = 0;
            end else if (en) begin
                m_samp[k][m_n[k]] = din ? (sign ? -1 : 1) : 0;
                m_n[k]++;
                if (m_n[k] == 8) begin
                    cap = 1'b1;
                    for (int j = 0; j < 8; j++) sum += m_samp[k][j];
                    m_n[k] = 0;
                    if (k == 0) m_act[k] = 1'b0;
                end
            end
            prev         = m_valid[k];
            m_overrun[k] = 1'b0;
            if (prev && rdy) m_valid[k] = 1'b0;
            if (cap) begin
                m_overrun[k] = prev && !rdy;
                m_valid[k]   = 1'b1;
                m_value[k]   = 5'(sum);
            end
        end
    endtask

    task automatic step(input logic s, input logic e, input logic i, input logic sg,
                        input logic r);
        @(negedge clk);
        start = s;
        en    = e;
        din   = i;
        sign  = sg;
        rdy   = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_init();
        @(negedge clk);
        init  = 1'b1;
        start = 1'b0;
        en    = 1'b0;
        model_reset();
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({value_c, valid_c, overrun_c, busy_c} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_c: got %h expected 00", {value_c, valid_c, overrun_c, busy_c});
        end
        tests_run++;
        if ({value_s, valid_s, overrun_s, busy_s} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_s: got %h expected 00", {value_s, valid_s, overrun_s, busy_s});
        end
        model_reset();
        @(negedge clk);
        init = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (busy_c !== 1'b0 || valid_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got busy=%b valid=%b expected 0 0", busy_c, valid_c);
        end
    endtask

    task automatic test_single_positive();
        do_init();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            if (i == 6) begin
                tests_run++;
                if (valid_s !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL single_early: got valid=%b expected 0", valid_s);
                end
            end
        end
        tests_run++;
        if (valid_s !== 1'b1 || value_s !== 5'sd8 || busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_capture: got valid=%b value=%0d busy=%b expected 1 8 0",
                     valid_s, value_s, busy_s);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (valid_s !== 1'b0 || busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_consume: got valid=%b busy=%b expected 0 0", valid_s, busy_s);
        end
    endtask

    task automatic test_negative_mix();
        do_init();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tests_run++;
        if (valid_s !== 1'b1 || value_s !== 5'b11101) begin
            tests_failed++;
            $display("FAIL negative_mix: got valid=%b value=%b expected 1 11101", valid_s, value_s);
        end
    endtask

    task automatic test_overrun();
        do_init();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 7) begin
                tests_run++;
                if (valid_c !== 1'b1 || value_c !== 5'sd8 || overrun_c !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL overrun_first: got valid=%b value=%0d ovr=%b expected 1 8 0",
                             valid_c, value_c, overrun_c);
                end
            end
        end
        tests_run++;
        if (overrun_c !== 1'b1 || value_c !== 5'sd8 || valid_c !== 1'b1 || busy_c !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_pulse: got ovr=%b value=%0d valid=%b busy=%b expected 1 8 1 1",
                     overrun_c, value_c, valid_c, busy_c);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (overrun_c !== 1'b0 || valid_c !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_one_cycle: got ovr=%b valid=%b expected 0 1", overrun_c, valid_c);
        end
    endtask

    task automatic test_en_toggle();
        do_init();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, (i % 2 == 0), 1'b1, 1'b0, 1'b0);
            if (i == 13) begin
                tests_run++;
                if (valid_c !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL en_toggle_early: got valid=%b expected 0", valid_c);
                end
            end
            if (i == 14) begin
                tests_run++;
                if (valid_c !== 1'b1 || value_c !== 5'sd8) begin
                    tests_failed++;
                    $display("FAIL en_toggle_capture: got valid=%b value=%0d expected 1 8",
                             valid_c, value_c);
                end
            end
        end
    endtask

    task automatic test_restart();
        do_init();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if (valid_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_old_boundary: got valid=%b expected 0", valid_c);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if (valid_c !== 1'b1 || value_c !== -5'sd8) begin
            tests_failed++;
            $display("FAIL restart_capture: got valid=%b value=%0d expected 1 -8", valid_c, value_c);
        end
    endtask

    task automatic test_init_mid();
        do_init();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // Assert reset away from any edge and look before the next one.
        init = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if ({value_c, valid_c, overrun_c, busy_c} !== 8'h00) begin
            tests_failed++;
            $display("FAIL init_async: got %h expected 00", {value_c, valid_c, overrun_c, busy_c});
        end
        @(negedge clk);
        init = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (valid_c !== 1'b0 || busy_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL init_waits_start: got valid=%b busy=%b expected 0 0", valid_c, busy_c);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_c, exp_s;
        do_init();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) do_init();
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 1'($urandom), 1'($urandom));
            exp_c = {m_value[1], m_valid[1], m_overrun[1], m_act[1]};
            exp_s = {m_value[0], m_valid[0], m_overrun[0], m_act[0]};
            tests_run++;
            if ({value_c, valid_c, overrun_c, busy_c} !== exp_c) begin
                tests_failed++;
                $display("FAIL random_c cycle %0d: got %h expected %h", n,
                         {value_c, valid_c, overrun_c, busy_c}, exp_c);
            end
            tests_run++;
            if ({value_s, valid_s, overrun_s, busy_s} !== exp_s) begin
                tests_failed++;
                $display("FAIL random_s cycle %0d: got %h expected %h", n,
                         {value_s, valid_s, overrun_s, busy_s}, exp_s);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        init  = 1'b1;
        din   = 1'b0;
        sign  = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        rdy   = 1'b0;
        test_reset();
        test_single_positive();
        test_negative_mix();
        test_overrun();
        test_en_toggle();
        test_restart();
        test_init_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
